// File: rtl/stage_sequencer.sv
// Parametrised one-hot stage sequencer with per-instruction skip mask, trap/irq arbitration
// at CONTROL and double-fault halt. Define STAGE_SEQ_PERF_EN to add cycle/retire counters.
module stage_sequencer #(
   parameter int NUM_STAGES   = 8,
   parameter int DECODE_STAGE = 2,
   parameter int NUM_IRQ      = 2,
   parameter int FAULT_W      = 3,
   localparam int IRQ_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_STAGES-1:0] stage_done,
   input  logic [NUM_STAGES-1:0] stage_skip,
   input  logic                  fault,
   input  logic [FAULT_W-1:0]    fault_code,
   input  logic [NUM_IRQ-1:0]    irq_pending,
   output logic [NUM_STAGES-1:0] stage_active,
   output logic [1:0]            control_op,
   output logic [IRQ_W-1:0]      irq_id,
   output logic [FAULT_W-1:0]    fault_num,
   output logic                  instr_retire,
   output logic                  halted
`ifdef STAGE_SEQ_PERF_EN
   ,
   output logic [63:0]           perf_cycles,
   output logic [63:0]           perf_retired
`endif
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   typedef enum logic {ST_RUN, ST_HALT} state_e;

   state_e                  state_q, state_d;
   logic [NUM_STAGES-1:0]   stage_q, stage_d;
   logic [NUM_STAGES-1:0]   skip_q, skip_d;
   logic [1:0]              op_q, op_d;
   logic [IRQ_W-1:0]        irq_id_q, irq_id_d;
   logic [FAULT_W-1:0]      fnum_q, fnum_d;
   logic                    retire_q, retire_d;
   logic                    trap_q, trap_d;

   logic [NUM_STAGES-1:0]   skip_load, skip_eff;
   logic [IDX_W-1:0]        cur_idx, nxt_idx;
   logic                    nxt_found, done_cur, dec_done;
   logic                    irq_found;
   logic [IRQ_W-1:0]        irq_sel;

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      skip_d   = skip_q;
      op_d     = op_q;
      irq_id_d = irq_id_q;
      fnum_d   = fnum_q;
      retire_d = 1'b0;
      trap_d   = trap_q;

      cur_idx = '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
         if (stage_q[i]) cur_idx = IDX_W'(i);
      end

      // Bits up to and including DECODE_STAGE can never be skipped.
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
         skip_load[i] = (i > unsigned'(DECODE_STAGE)) && stage_skip[i];
      end

      done_cur = stage_done[cur_idx];
      dec_done = stage_q[DECODE_STAGE] && stage_done[DECODE_STAGE];
      // The mask sampled at decode completion already steers that same transition.
      skip_eff = dec_done ? skip_load : skip_q;

      nxt_idx   = '0;
      nxt_found = 1'b0;
      for (int unsigned j = 1; j < NUM_STAGES; j++) begin
         if (!nxt_found && (IDX_W'(j) > cur_idx) && !skip_eff[j]) begin
            nxt_idx   = IDX_W'(j);
            nxt_found = 1'b1;
         end
      end

      irq_found = 1'b0;
      irq_sel   = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (!irq_found && irq_pending[i]) begin
            irq_found = 1'b1;
            irq_sel   = IRQ_W'(i);
         end
      end

      if (state_q == ST_RUN) begin
         if (fault) begin
            fnum_d = fault_code;
            if (op_q == 2'b00) begin
               state_d = ST_HALT;
               stage_d = '0;
            end else begin
               stage_d    = '0;
               stage_d[0] = 1'b1;
               trap_d     = 1'b1;
               skip_d     = '0;
            end
         end else if (stage_q[0]) begin
            stage_d    = '0;
            stage_d[1] = 1'b1;
            if (trap_q) begin
               op_d   = 2'b00;
               trap_d = 1'b0;
            end else if (irq_found) begin
               op_d     = 2'b01;
               irq_id_d = irq_sel;
            end else begin
               op_d = 2'b11;
            end
         end else if (done_cur) begin
            if (dec_done) skip_d = skip_load;
            stage_d          = '0;
            stage_d[nxt_idx] = 1'b1;
            if (!nxt_found) begin
               skip_d   = '0;
               retire_d = (op_q == 2'b11);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_RUN;
         stage_q  <= NUM_STAGES'(1);
         skip_q   <= '0;
         op_q     <= 2'b11;
         irq_id_q <= '0;
         fnum_q   <= '0;
         retire_q <= 1'b0;
         trap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         skip_q   <= skip_d;
         op_q     <= op_d;
         irq_id_q <= irq_id_d;
         fnum_q   <= fnum_d;
         retire_q <= retire_d;
         trap_q   <= trap_d;
      end
   end

   assign stage_active = stage_q;
   assign control_op   = op_q;
   assign irq_id       = irq_id_q;
   assign fault_num    = fnum_q;
   assign instr_retire = retire_q;
   assign halted       = (state_q == ST_HALT);

`ifdef STAGE_SEQ_PERF_EN
   logic [63:0] perf_cycles_q, perf_cycles_d;
   logic [63:0] perf_retired_q, perf_retired_d;

   always_comb begin
      perf_cycles_d  = perf_cycles_q + ((state_q == ST_RUN) ? 64'd1 : 64'd0);
      perf_retired_d = perf_retired_q + (retire_q ? 64'd1 : 64'd0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_cycles_q  <= '0;
         perf_retired_q <= '0;
      end else begin
         perf_cycles_q  <= perf_cycles_d;
         perf_retired_q <= perf_retired_d;
      end
   end

   assign perf_cycles  = perf_cycles_q;
   assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer (8 stages, decode at 2, 2 irq lines, 3-bit faults).
module tb_stage_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] stage_done, stage_skip;
   logic       fault;
   logic [2:0] fault_code;
   logic [1:0] irq_pending;
   logic [7:0] stage_active;
   logic [1:0] control_op;
   logic       irq_id;
   logic [2:0] fault_num;
   logic       instr_retire, halted;
`ifdef STAGE_SEQ_PERF_EN
   logic [63:0] perf_cycles, perf_retired;
`endif

   stage_sequencer #(.NUM_STAGES(8), .DECODE_STAGE(2), .NUM_IRQ(2), .FAULT_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .stage_done(stage_done), .stage_skip(stage_skip),
      .fault(fault), .fault_code(fault_code), .irq_pending(irq_pending),
      .stage_active(stage_active), .control_op(control_op), .irq_id(irq_id),
      .fault_num(fault_num), .instr_retire(instr_retire), .halted(halted)
`ifdef STAGE_SEQ_PERF_EN
      , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] act;
      logic [1:0] op;
      logic       irq;
      logic [2:0] fn;
      logic       ret;
      logic       halt;
   } exp_t;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   // Reference model state
   int         m_stage;
   logic [1:0] m_op;
   logic       m_irq;
   logic [2:0] m_fn;
   logic       m_ret, m_halt, m_trap;
   logic [7:0] m_skip;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_stage = 0; m_op = 2'b11; m_irq = 1'b0; m_fn = 3'd0;
      m_ret = 1'b0; m_halt = 1'b0; m_trap = 1'b0; m_skip = 8'h00;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_act"},  stage_active, 8'h01);
      check({tag, "_op"},   control_op,   2'b11);
      check({tag, "_irq"},  irq_id,       1'b0);
      check({tag, "_fn"},   fault_num,    3'd0);
      check({tag, "_ret"},  instr_retire, 1'b0);
      check({tag, "_halt"}, halted,       1'b0);
`ifdef STAGE_SEQ_PERF_EN
      check({tag, "_pcyc"}, perf_cycles,  64'd0);
      check({tag, "_pret"}, perf_retired, 64'd0);
`endif
   endtask

   // Drive one cycle, push the model's prediction, then pop and compare after the edge.
   task automatic step(input logic [7:0] dn, input logic [7:0] sk, input logic flt,
                       input logic [2:0] fc, input logic [1:0] irq);
      exp_t e;
      int   j;
      stage_done = dn; stage_skip = sk; fault = flt; fault_code = fc; irq_pending = irq;
      m_ret = 1'b0;
      if (!m_halt) begin
         if (flt) begin
            m_fn = fc;
            if (m_op == 2'b00) m_halt = 1'b1;
            else begin m_stage = 0; m_trap = 1'b1; m_skip = 8'h00; end
         end else if (m_stage == 0) begin
            m_stage = 1;
            if (m_trap) begin m_op = 2'b00; m_trap = 1'b0; end
            else if (irq[0]) begin m_op = 2'b01; m_irq = 1'b0; end
            else if (irq[1]) begin m_op = 2'b01; m_irq = 1'b1; end
            else m_op = 2'b11;
         end else if (dn[m_stage]) begin
            if (m_stage == 2) m_skip = sk & 8'b1111_1000;
            j = m_stage + 1;
            while (j < 8 && m_skip[j]) j++;
            if (j == 8) begin m_stage = 0; m_skip = 8'h00; m_ret = (m_op == 2'b11); end
            else m_stage = j;
         end
      end
      e.act  = m_halt ? 8'h00 : 8'(1 << m_stage);
      e.op   = m_op;   e.irq = m_irq; e.fn = m_fn;
      e.ret  = m_ret;  e.halt = m_halt;
      sb_q.push_back(e);
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         check("act",  stage_active, e.act);
         check("op",   control_op,   e.op);
         check("irq",  irq_id,       e.irq);
         check("fn",   fault_num,    e.fn);
         check("ret",  instr_retire, e.ret);
         check("halt", halted,       e.halt);
      end
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      stage_done = 8'h00; stage_skip = 8'h00; fault = 1'b0; fault_code = 3'd0; irq_pending = 2'b00;
      #2;
      check_reset_outputs(tag);
      sb_q.delete();
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         cnt;
      logic [47:0] seq;
      logic       flt;

      reset_n = 1'b0;
      stage_done = 8'h00; stage_skip = 8'h00; fault = 1'b0; fault_code = 3'd0; irq_pending = 2'b00;
      model_reset();
      #22;
      check_reset_outputs("rst0");
      @(negedge clk);
      reset_n = 1'b1;

      // 1: straight walk through all eight stages
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b00);
         if (instr_retire) cnt++;
      end
      check("t1_retires", cnt, 2);

      // 2: skip stages 3 and 5
      seq = '0;
      for (int i = 0; i < 6; i++) begin
         step(8'hFF, 8'b0010_1000, 1'b0, 3'd0, 2'b00);
         seq = {seq[39:0], stage_active};
      end
      check("t2_seq", seq, 48'h02_04_10_40_80_01);
      check("t2_ret", instr_retire, 1'b1);

      // 3: fault with done in stage 4, then trap beats a pending irq
      for (int i = 0; i < 4; i++) step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b00);
      check("t3_in4", stage_active, 8'h10);
      step(8'hFF, 8'h00, 1'b1, 3'd5, 2'b00);
      check("t3_ctrl", stage_active, 8'h01);
      check("t3_fn", fault_num, 3'd5);
      check("t3_noret", instr_retire, 1'b0);
      step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b10);
      check("t3_trap", control_op, 2'b00);
      for (int i = 0; i < 7; i++) step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b10);
      step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b10);
      check("t4_irq1_op", control_op, 2'b01);
      check("t4_irq1_id", irq_id, 1'b1);
      for (int i = 0; i < 7; i++) step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b00);

      // 4: both irq lines, line 0 wins
      step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b11);
      check("t4_irq0_op", control_op, 2'b01);
      check("t4_irq0_id", irq_id, 1'b0);
      for (int i = 0; i < 7; i++) step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b00);

      // 5: fault inside a trap instruction halts
      step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b00);
      step(8'h00, 8'h00, 1'b1, 3'd2, 2'b00);
      step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b00);
      step(8'h00, 8'h00, 1'b1, 3'd6, 2'b00);
      check("t5_halt", halted, 1'b1);
      check("t5_act", stage_active, 8'h00);
      check("t5_fn", fault_num, 3'd6);
      for (int i = 0; i < 5; i++) step(8'hFF, 8'h00, 1'b0, 3'd1, 2'b11);
      check("t5_sticky", halted, 1'b1);

      // 6: asynchronous reset in the middle of stage 3
      do_reset("rst1");
      for (int i = 0; i < 3; i++) step(8'hFF, 8'h00, 1'b0, 3'd0, 2'b00);
      step(8'h00, 8'h00, 1'b0, 3'd0, 2'b00);
      check("t6_in3", stage_active, 8'h08);
      #3;
      do_reset("rst_mid");

      // Randomised traffic, recovering from halts with a reset
      for (int i = 0; i < 300; i++) begin
         flt = (m_stage != 0) && !m_halt && ($urandom_range(0, 15) == 0);
         step(8'($urandom | $urandom), 8'($urandom), flt, 3'($urandom), 2'($urandom));
         if (m_halt && $urandom_range(0, 3) == 0) do_reset("rst_rnd");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
